// File: rtl/divrem_pipe.sv
`default_nettype none
// ============================================================================
// Module   : divrem_pipe
// Function : Iterative restoring unsigned divider, BITS_PER_CYCLE quotient
//            bits per clock, go/ready handshake. Optional macro
//            DIVREM_SIGNED_EN adds a sign input for two's-complement operands.
// Revision : 1.0 - initial release
// ============================================================================
module divrem_pipe #(
    parameter int WIDTH          = 16,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             go,
    input  logic [WIDTH-1:0] num,
    input  logic [WIDTH-1:0] den,
`ifdef DIVREM_SIGNED_EN
    input  logic             sign,
`endif
    output logic             ready,
    output logic             error,
    output logic [WIDTH-1:0] quot,
    output logic [WIDTH-1:0] rem
);

    localparam int c_N  = WIDTH / BITS_PER_CYCLE;
    localparam int c_CW = $clog2(c_N + 1);

    generate
        if (WIDTH < 2 || !(BITS_PER_CYCLE == 1 || BITS_PER_CYCLE == 2 ||
                           BITS_PER_CYCLE == 4) || (WIDTH % BITS_PER_CYCLE) != 0)
        begin : g_bad_param
            $error("divrem_pipe: unsupported WIDTH/BITS_PER_CYCLE combination");
        end
    endgenerate

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_CALC = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;

    logic [WIDTH-1:0]  r_pr;      // partial remainder, always < divisor
    logic [WIDTH-1:0]  r_qs;      // dividend bits shift out, quotient bits shift in
    logic [WIDTH-1:0]  r_den;
    logic [c_CW-1:0]   r_cnt;
    logic              r_neg_q;
    logic              r_neg_r;
    logic              r_error;
    logic [WIDTH-1:0]  r_quot;
    logic [WIDTH-1:0]  r_rem;

    logic              w_accept;
    logic              w_last;
    logic              w_den_zero;
    logic [WIDTH-1:0]  w_num_mag;
    logic [WIDTH-1:0]  w_den_mag;
    logic              w_num_neg;
    logic              w_den_neg;
    logic [WIDTH-1:0]  w_q_fix;
    logic [WIDTH-1:0]  w_r_fix;

    logic [WIDTH-1:0]  w_pr [0:BITS_PER_CYCLE];
    logic [WIDTH-1:0]  w_qs [0:BITS_PER_CYCLE];

`ifdef DIVREM_SIGNED_EN
    assign w_num_neg = sign & num[WIDTH-1];
    assign w_den_neg = sign & den[WIDTH-1];
`else
    assign w_num_neg = 1'b0;
    assign w_den_neg = 1'b0;
`endif
    // MIN/-1 needs no special case: |MIN| = 2^(WIDTH-1) is the MIN bit pattern.
    assign w_num_mag  = w_num_neg ? (~num + 1'b1) : num;
    assign w_den_mag  = w_den_neg ? (~den + 1'b1) : den;
    assign w_den_zero = (den == '0);

    assign w_accept = (r_state == S_IDLE) && go;
    assign w_last   = (r_state == S_CALC) && (r_cnt == c_CW'(1));

    assign w_pr[0] = r_pr;
    assign w_qs[0] = r_qs;

    generate
        for (genvar gi = 0; gi < BITS_PER_CYCLE; gi++) begin : g_step
            // The shifted trial value needs WIDTH+1 bits before the compare.
            logic [WIDTH:0] w_sh;
            logic           w_ge;
            assign w_sh = {w_pr[gi], w_qs[gi][WIDTH-1]};
            assign w_ge = (w_sh >= {1'b0, r_den});
            assign w_pr[gi+1] = w_ge ? WIDTH'(w_sh - {1'b0, r_den}) : w_sh[WIDTH-1:0];
            assign w_qs[gi+1] = {w_qs[gi][WIDTH-2:0], w_ge};
        end
    endgenerate

    assign w_q_fix = r_neg_q ? (~w_qs[BITS_PER_CYCLE] + 1'b1) : w_qs[BITS_PER_CYCLE];
    assign w_r_fix = r_neg_r ? (~w_pr[BITS_PER_CYCLE] + 1'b1) : w_pr[BITS_PER_CYCLE];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (go && !w_den_zero) begin
                    w_state_nxt = S_CALC;
                end
            end
            S_CALC: begin
                if (r_cnt == c_CW'(1)) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pr    <= '0;
            r_qs    <= '0;
            r_den   <= '0;
            r_cnt   <= '0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
            r_error <= 1'b0;
            r_quot  <= '0;
            r_rem   <= '0;
        end else if (w_accept) begin
            r_error <= w_den_zero;
            if (w_den_zero) begin
                r_quot <= '1;
                r_rem  <= num;
            end else begin
                r_pr    <= '0;
                r_qs    <= w_num_mag;
                r_den   <= w_den_mag;
                r_cnt   <= c_CW'(c_N);
                r_neg_q <= w_num_neg ^ w_den_neg;
                r_neg_r <= w_num_neg;
            end
        end else if (r_state == S_CALC) begin
            r_pr  <= w_pr[BITS_PER_CYCLE];
            r_qs  <= w_qs[BITS_PER_CYCLE];
            r_cnt <= r_cnt - 1'b1;
            if (w_last) begin
                r_quot <= w_q_fix;
                r_rem  <= w_r_fix;
            end
        end
    end

    assign ready = (r_state == S_IDLE);
    assign error = r_error;
    assign quot  = r_quot;
    assign rem   = r_rem;

endmodule
`default_nettype wire

// File: tb/tb_divrem_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_divrem_pipe
// Function : Directed self-checking bench for divrem_pipe (BPC=1 and BPC=4
//            instances; signed WIDTH=8 instance when DIVREM_SIGNED_EN is set).
// Revision : 1.0 - initial release
// ============================================================================
module tb_divrem_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        go;
    logic [15:0] num;
    logic [15:0] den;
    logic        ready_a, error_a, ready_b, error_b;
    logic [15:0] quot_a, rem_a, quot_b, rem_b;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    divrem_pipe #(.WIDTH(16), .BITS_PER_CYCLE(1)) u_dut_a (
        .clk(clk), .rst(rst), .go(go), .num(num), .den(den),
`ifdef DIVREM_SIGNED_EN
        .sign(1'b0),
`endif
        .ready(ready_a), .error(error_a), .quot(quot_a), .rem(rem_a)
    );

    divrem_pipe #(.WIDTH(16), .BITS_PER_CYCLE(4)) u_dut_b (
        .clk(clk), .rst(rst), .go(go), .num(num), .den(den),
`ifdef DIVREM_SIGNED_EN
        .sign(1'b0),
`endif
        .ready(ready_b), .error(error_b), .quot(quot_b), .rem(rem_b)
    );

`ifdef DIVREM_SIGNED_EN
    logic       go_s, sign_s, ready_s, error_s;
    logic [7:0] num_s, den_s, quot_s, rem_s;

    divrem_pipe #(.WIDTH(8), .BITS_PER_CYCLE(2)) u_dut_s (
        .clk(clk), .rst(rst), .go(go_s), .num(num_s), .den(den_s),
        .sign(sign_s),
        .ready(ready_s), .error(error_s), .quot(quot_s), .rem(rem_s)
    );
`endif

    // Issue one op on the shared inputs; cyc counts cycles from E0 until ready.
    task automatic run_op(input logic [15:0] n, input logic [15:0] d, input bit sel_b,
                          output logic rdy0, output int cyc);
        @(negedge clk);
        num = n; den = d; go = 1'b1;
        @(negedge clk);
        go   = 1'b0;
        rdy0 = sel_b ? ready_b : ready_a;
        cyc  = 0;
        while (!(sel_b ? ready_b : ready_a) && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; go = 1'b0; num = '0; den = '0;
`ifdef DIVREM_SIGNED_EN
        go_s = 1'b0; sign_s = 1'b0; num_s = '0; den_s = '0;
`endif
        repeat (3) @(negedge clk);
        checks++; if (ready_a !== 1'b1) begin errors++; $display("FAIL reset_ready_a got=%b exp=1", ready_a); end
        checks++; if (error_a !== 1'b0) begin errors++; $display("FAIL reset_error_a got=%b exp=0", error_a); end
        checks++; if (quot_a !== 16'd0) begin errors++; $display("FAIL reset_quot_a got=%h exp=0", quot_a); end
        checks++; if (rem_a !== 16'd0)  begin errors++; $display("FAIL reset_rem_a got=%h exp=0", rem_a); end
        checks++; if (ready_b !== 1'b1) begin errors++; $display("FAIL reset_ready_b got=%b exp=1", ready_b); end
        checks++; if (quot_b !== 16'd0) begin errors++; $display("FAIL reset_quot_b got=%h exp=0", quot_b); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_exhaustive;
        logic rdy0;
        int   cyc;
        for (int n = 0; n < 20; n++) begin
            for (int d = 1; d < 20; d++) begin
                run_op(16'(n), 16'(d), 1'b0, rdy0, cyc);
                checks++; if (rdy0 !== 1'b0) begin errors++; $display("FAIL exh_ready_fall %0d/%0d got=%b exp=0", n, d, rdy0); end
                checks++; if (cyc != 16) begin errors++; $display("FAIL exh_latency %0d/%0d got=%0d exp=16", n, d, cyc); end
                checks++; if (quot_a !== 16'(n / d)) begin errors++; $display("FAIL exh_quot %0d/%0d got=%0d exp=%0d", n, d, quot_a, n / d); end
                checks++; if (rem_a !== 16'(n % d)) begin errors++; $display("FAIL exh_rem %0d/%0d got=%0d exp=%0d", n, d, rem_a, n % d); end
                checks++; if (error_a !== 1'b0) begin errors++; $display("FAIL exh_error %0d/%0d got=%b exp=0", n, d, error_a); end
            end
        end
    endtask

    task automatic test_div_zero;
        logic rdy0;
        int   cyc;
        run_op(16'd37, 16'd0, 1'b0, rdy0, cyc);
        checks++; if (rdy0 !== 1'b1) begin errors++; $display("FAIL dz_ready got=%b exp=1", rdy0); end
        checks++; if (error_a !== 1'b1) begin errors++; $display("FAIL dz_error got=%b exp=1", error_a); end
        checks++; if (quot_a !== 16'hFFFF) begin errors++; $display("FAIL dz_quot got=%h exp=ffff", quot_a); end
        checks++; if (rem_a !== 16'd37) begin errors++; $display("FAIL dz_rem got=%0d exp=37", rem_a); end
        run_op(16'd100, 16'd7, 1'b0, rdy0, cyc);
        checks++; if (error_a !== 1'b0) begin errors++; $display("FAIL dz_next_error got=%b exp=0", error_a); end
        checks++; if (quot_a !== 16'd14) begin errors++; $display("FAIL dz_next_quot got=%0d exp=14", quot_a); end
        checks++; if (rem_a !== 16'd2) begin errors++; $display("FAIL dz_next_rem got=%0d exp=2", rem_a); end
    endtask

    task automatic test_bpc4;
        logic rdy0;
        int   cyc;
        run_op(16'hFFFF, 16'd1, 1'b1, rdy0, cyc);
        checks++; if (cyc != 4) begin errors++; $display("FAIL bpc4_latency got=%0d exp=4", cyc); end
        checks++; if (quot_b !== 16'hFFFF) begin errors++; $display("FAIL bpc4_max_quot got=%h exp=ffff", quot_b); end
        checks++; if (rem_b !== 16'd0) begin errors++; $display("FAIL bpc4_max_rem got=%h exp=0", rem_b); end
        run_op(16'd1000, 16'd1001, 1'b1, rdy0, cyc);
        checks++; if (quot_b !== 16'd0) begin errors++; $display("FAIL bpc4_lt_quot got=%0d exp=0", quot_b); end
        checks++; if (rem_b !== 16'd1000) begin errors++; $display("FAIL bpc4_lt_rem got=%0d exp=1000", rem_b); end
        run_op(16'd1234, 16'd1234, 1'b1, rdy0, cyc);
        checks++; if (quot_b !== 16'd1 || rem_b !== 16'd0) begin errors++; $display("FAIL bpc4_eq got=%0d,%0d exp=1,0", quot_b, rem_b); end
        // Wait out the BPC=1 instance started by the same stimulus.
        while (!ready_a) @(negedge clk);
    endtask

    task automatic test_reset_abort;
        logic rdy0;
        int   cyc;
        @(negedge clk);
        num = 16'd500; den = 16'd3; go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++; if (ready_a !== 1'b1) begin errors++; $display("FAIL abort_ready got=%b exp=1", ready_a); end
        checks++; if (quot_a !== 16'd0) begin errors++; $display("FAIL abort_quot got=%0d exp=0", quot_a); end
        checks++; if (rem_a !== 16'd0) begin errors++; $display("FAIL abort_rem got=%0d exp=0", rem_a); end
        checks++; if (error_a !== 1'b0) begin errors++; $display("FAIL abort_error got=%b exp=0", error_a); end
        run_op(16'd500, 16'd3, 1'b0, rdy0, cyc);
        checks++; if (quot_a !== 16'd166 || rem_a !== 16'd2) begin errors++; $display("FAIL abort_next got=%0d,%0d exp=166,2", quot_a, rem_a); end
    endtask

    task automatic test_ignore_go;
        int cyc;
        @(negedge clk);
        num = 16'd81; den = 16'd9; go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        cyc = 0;
        repeat (3) begin @(negedge clk); cyc++; end
        num = 16'd200; den = 16'd3; go = 1'b1;
        @(negedge clk); cyc++;
        go = 1'b0;
        while (!ready_a && cyc < 100) begin @(negedge clk); cyc++; end
        checks++; if (cyc != 16) begin errors++; $display("FAIL ignore_latency got=%0d exp=16", cyc); end
        checks++; if (quot_a !== 16'd9) begin errors++; $display("FAIL ignore_quot got=%0d exp=9", quot_a); end
        checks++; if (rem_a !== 16'd0) begin errors++; $display("FAIL ignore_rem got=%0d exp=0", rem_a); end
    endtask

    task automatic test_back_to_back;
        logic [15:0] n_tab [3] = '{16'd50, 16'd1234, 16'd65535};
        logic [15:0] d_tab [3] = '{16'd7,  16'd10,   16'd255};
        logic [15:0] q_tab [3] = '{16'd7,  16'd123,  16'd257};
        logic [15:0] r_tab [3] = '{16'd1,  16'd4,    16'd0};
        int cyc;
        @(negedge clk);
        num = n_tab[0]; den = d_tab[0]; go = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            checks++; if (ready_a !== 1'b0) begin errors++; $display("FAIL b2b_busy op%0d got=%b exp=0", k, ready_a); end
            cyc = 0;
            while (!ready_a && cyc < 100) begin @(negedge clk); cyc++; end
            checks++; if (cyc != 16) begin errors++; $display("FAIL b2b_latency op%0d got=%0d exp=16", k, cyc); end
            checks++; if (quot_a !== q_tab[k]) begin errors++; $display("FAIL b2b_quot op%0d got=%0d exp=%0d", k, quot_a, q_tab[k]); end
            checks++; if (rem_a !== r_tab[k]) begin errors++; $display("FAIL b2b_rem op%0d got=%0d exp=%0d", k, rem_a, r_tab[k]); end
            if (k < 2) begin
                num = n_tab[k+1]; den = d_tab[k+1];
            end else begin
                go = 1'b0;
            end
            @(negedge clk);
        end
        checks++; if (ready_a !== 1'b1) begin errors++; $display("FAIL b2b_idle got=%b exp=1", ready_a); end
    endtask

`ifdef DIVREM_SIGNED_EN
    task automatic test_signed;
        logic [7:0] n_tab [4] = '{8'hF9, 8'h07, 8'h80, 8'hF9};
        logic [7:0] d_tab [4] = '{8'h02, 8'hFE, 8'hFF, 8'h02};
        logic       s_tab [4] = '{1'b1,  1'b1,  1'b1,  1'b0};
        logic [7:0] q_tab [4] = '{8'hFD, 8'hFD, 8'h80, 8'd124};
        logic [7:0] r_tab [4] = '{8'hFF, 8'h01, 8'h00, 8'd1};
        int cyc;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            num_s = n_tab[k]; den_s = d_tab[k]; sign_s = s_tab[k]; go_s = 1'b1;
            @(negedge clk);
            go_s = 1'b0;
            cyc = 0;
            while (!ready_s && cyc < 100) begin @(negedge clk); cyc++; end
            checks++; if (cyc != 4) begin errors++; $display("FAIL signed_latency op%0d got=%0d exp=4", k, cyc); end
            checks++; if (quot_s !== q_tab[k]) begin errors++; $display("FAIL signed_quot op%0d got=%h exp=%h", k, quot_s, q_tab[k]); end
            checks++; if (rem_s !== r_tab[k]) begin errors++; $display("FAIL signed_rem op%0d got=%h exp=%h", k, rem_s, r_tab[k]); end
            checks++; if (error_s !== 1'b0) begin errors++; $display("FAIL signed_error op%0d got=%b exp=0", k, error_s); end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_exhaustive();
        test_div_zero();
        test_bpc4();
        test_reset_abort();
        test_ignore_go();
        test_back_to_back();
`ifdef DIVREM_SIGNED_EN
        test_signed();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
